score_counter: RTL and testbench

//   Consumer end of the pushbutton count_up/count_down pulse interface.

---
 rtl/score_counter.sv | 163 ++++++++++++++++
 tb/tb_score_counter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/score_counter.sv
// rtl/score_counter.sv - saturating two-digit BCD score counter with limit flag and muxed 7-segment drive
// Pulse inputs are edge-detected so one press is one event regardless of its width.
module score_counter #(
  parameter int MAX_SCORE  = 99,
  parameter int MUX_PERIOD = 5,
  parameter int LIMIT_TIME = 500
) (
  input  logic       clk_1khz,
  input  logic       rst_n_i,
  input  logic       count_up_i,
  input  logic       count_down_i,
  input  logic       clear_i,
  output logic [3:0] score_tens_o,
  output logic [3:0] score_ones_o,
  output logic [6:0] seg_o,
  output logic [1:0] digit_sel_o,
  output logic       limit_o
);

  localparam int LW = $clog2(LIMIT_TIME + 1);
  localparam int MW = (MUX_PERIOD > 1) ? $clog2(MUX_PERIOD) : 1;

  localparam logic [3:0]    MAX_TENS  = 4'(MAX_SCORE / 10);
  localparam logic [3:0]    MAX_ONES  = 4'(MAX_SCORE % 10);
  localparam logic [LW-1:0] LIMIT_LD  = LW'(LIMIT_TIME);
  localparam logic [MW-1:0] MUX_LAST  = MW'(MUX_PERIOD - 1);

  localparam logic [0:0] ST_ONES = 1'b0;
  localparam logic [0:0] ST_TENS = 1'b1;

  logic          r_up_q;
  logic          r_dn_q;
  logic [3:0]    r_tens;
  logic [3:0]    r_ones;
  logic          r_limit;
  logic [LW-1:0] r_limit_cnt;
  logic [0:0]    r_mux_state;
  logic [MW-1:0] r_mux_cnt;
  logic [1:0]    r_digit_sel;
  logic [6:0]    r_seg;

  logic          w_up_ev;
  logic          w_dn_ev;
  logic          w_at_max;
  logic          w_at_zero;
  logic [3:0]    w_tens_nxt;
  logic [3:0]    w_ones_nxt;
  logic          w_limit_start;
  logic          w_mux_switch;
  logic [0:0]    w_state_nxt;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg_nxt;

  assign w_up_ev   = count_up_i & ~r_up_q;
  assign w_dn_ev   = count_down_i & ~r_dn_q;
  assign w_at_max  = (r_tens == MAX_TENS) && (r_ones == MAX_ONES);
  assign w_at_zero = (r_tens == 4'd0) && (r_ones == 4'd0);

  // Simultaneous up and down events cancel; clear beats everything.
  always_comb begin
    w_tens_nxt    = r_tens;
    w_ones_nxt    = r_ones;
    w_limit_start = 1'b0;
    if (clear_i) begin
      w_tens_nxt = 4'd0;
      w_ones_nxt = 4'd0;
    end else if (w_up_ev && !w_dn_ev) begin
      if (w_at_max) begin
        w_limit_start = 1'b1;
      end else if (r_ones == 4'd9) begin
        w_ones_nxt = 4'd0;
        w_tens_nxt = r_tens + 4'd1;
      end else begin
        w_ones_nxt = r_ones + 4'd1;
      end
    end else if (w_dn_ev && !w_up_ev) begin
      if (w_at_zero) begin
        w_limit_start = 1'b1;
      end else if (r_ones == 4'd0) begin
        w_ones_nxt = 4'd9;
        w_tens_nxt = r_tens - 4'd1;
      end else begin
        w_ones_nxt = r_ones - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_1khz or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_up_q <= 1'b1;
      r_dn_q <= 1'b1;
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else begin
      r_up_q <= count_up_i;
      r_dn_q <= count_down_i;
      r_tens <= w_tens_nxt;
      r_ones <= w_ones_nxt;
    end
  end

  // Flag drops on the edge where the counter reaches zero: LIMIT_TIME cycles high.
  always_ff @(posedge clk_1khz or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_limit     <= 1'b0;
      r_limit_cnt <= '0;
    end else if (w_limit_start) begin
      r_limit     <= 1'b1;
      r_limit_cnt <= LIMIT_LD;
    end else if (r_limit_cnt != '0) begin
      r_limit     <= (r_limit_cnt != LW'(1));
      r_limit_cnt <= r_limit_cnt - LW'(1);
    end else begin
      r_limit     <= 1'b0;
    end
  end

  assign w_mux_switch = (r_mux_cnt == MUX_LAST);
  assign w_state_nxt  = w_mux_switch ? ~r_mux_state : r_mux_state;
  assign w_digit      = (w_state_nxt == ST_TENS) ? r_tens : r_ones;

  always_comb begin
    w_seg_nxt = 7'h00;
    case (w_digit)
      4'd0:    w_seg_nxt = 7'h3F;
      4'd1:    w_seg_nxt = 7'h06;
      4'd2:    w_seg_nxt = 7'h5B;
      4'd3:    w_seg_nxt = 7'h4F;
      4'd4:    w_seg_nxt = 7'h66;
      4'd5:    w_seg_nxt = 7'h6D;
      4'd6:    w_seg_nxt = 7'h7D;
      4'd7:    w_seg_nxt = 7'h07;
      4'd8:    w_seg_nxt = 7'h7F;
      4'd9:    w_seg_nxt = 7'h6F;
      default: w_seg_nxt = 7'h00;
    endcase
    if ((w_state_nxt == ST_TENS) && (r_tens == 4'd0)) begin
      w_seg_nxt = 7'h00;
    end
  end

  // Select and segments are registered from the same next-state so they never skew.
  always_ff @(posedge clk_1khz or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mux_state <= ST_ONES;
      r_mux_cnt   <= '0;
      r_digit_sel <= 2'b01;
      r_seg       <= 7'h3F;
    end else begin
      r_mux_state <= w_state_nxt;
      r_mux_cnt   <= w_mux_switch ? '0 : r_mux_cnt + MW'(1);
      r_digit_sel <= (w_state_nxt == ST_TENS) ? 2'b10 : 2'b01;
      r_seg       <= w_seg_nxt;
    end
  end

  assign score_tens_o = r_tens;
  assign score_ones_o = r_ones;
  assign seg_o        = r_seg;
  assign digit_sel_o  = r_digit_sel;
  assign limit_o      = r_limit;

endmodule

// File: tb/tb_score_counter.sv
// tb/tb_score_counter.sv - directed self-checking bench for score_counter
module tb_score_counter;

  logic       clk_1khz = 1'b0;
  logic       rst_n_i;
  logic       count_up_i;
  logic       count_down_i;
  logic       clear_i;
  logic [3:0] score_tens_o;
  logic [3:0] score_ones_o;
  logic [6:0] seg_o;
  logic [1:0] digit_sel_o;
  logic       limit_o;

  int n_tests = 0;
  int n_fail  = 0;

  score_counter #(.MAX_SCORE(99), .MUX_PERIOD(5), .LIMIT_TIME(500)) dut (
    .clk_1khz     (clk_1khz),
    .rst_n_i      (rst_n_i),
    .count_up_i   (count_up_i),
    .count_down_i (count_down_i),
    .clear_i      (clear_i),
    .score_tens_o (score_tens_o),
    .score_ones_o (score_ones_o),
    .seg_o        (seg_o),
    .digit_sel_o  (digit_sel_o),
    .limit_o      (limit_o)
  );

  always #5 clk_1khz = ~clk_1khz;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int score();
    return int'(score_tens_o) * 10 + int'(score_ones_o);
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic pulse(input logic up, input int width);
    count_up_i   = up;
    count_down_i = ~up;
    repeat (width) @(negedge clk_1khz);
    count_up_i   = 1'b0;
    count_down_i = 1'b0;
    @(negedge clk_1khz);
  endtask

  initial begin
    int n;
    int n_sel1;
    int n_sel2;
    int n_bad;
    logic [1:0] sel_hist [20];

    rst_n_i      = 1'b0;
    count_up_i   = 1'b1;
    count_down_i = 1'b0;
    clear_i      = 1'b0;
    repeat (3) @(negedge clk_1khz);
    check("rst_score", score(), 0);
    check("rst_limit", int'(limit_o), 0);
    check("rst_sel", int'(digit_sel_o), 1);
    check("rst_seg", int'(seg_o), 'h3F);

    // up held across reset release must not count
    rst_n_i = 1'b1;
    repeat (3) @(negedge clk_1khz);
    check("held_at_release", score(), 0);
    count_up_i = 1'b0;
    @(negedge clk_1khz);

    count_up_i = 1'b1;
    @(negedge clk_1khz);
    check("first_edge", score(), 1);
    repeat (4) @(negedge clk_1khz);
    check("wide_pulse_once", score(), 1);
    count_up_i = 1'b0;
    @(negedge clk_1khz);
    check("after_pulse", score(), 1);

    repeat (8) pulse(1'b1, 2);
    check("to_09", score(), 9);
    pulse(1'b1, 3);
    check("carry_09_10", score(), 10);
    pulse(1'b0, 3);
    check("borrow_10_09", score(), 9);

    clear_i    = 1'b1;
    count_up_i = 1'b1;
    @(negedge clk_1khz);
    check("clear_beats_up", score(), 0);
    check("clear_no_limit", int'(limit_o), 0);
    clear_i    = 1'b0;
    count_up_i = 1'b0;
    @(negedge clk_1khz);

    pulse(1'b1, 1);
    count_up_i   = 1'b1;
    count_down_i = 1'b1;
    @(negedge clk_1khz);
    check("both_edges", score(), 1);
    check("both_no_limit", int'(limit_o), 0);
    count_up_i   = 1'b0;
    count_down_i = 1'b0;
    @(negedge clk_1khz);

    repeat (6) pulse(1'b1, 1);
    check("to_07", score(), 7);
    repeat (2) @(negedge clk_1khz);
    n_sel1 = 0;
    n_sel2 = 0;
    n_bad  = 0;
    for (int i = 0; i < 20; i++) begin
      sel_hist[i] = digit_sel_o;
      if (digit_sel_o == 2'b01 && seg_o == 7'h07) n_sel1++;
      else if (digit_sel_o == 2'b10 && seg_o == 7'h00) n_sel2++;
      @(negedge clk_1khz);
    end
    for (int i = 5; i < 20; i++) begin
      if (sel_hist[i] == sel_hist[i-5]) n_bad++;
    end
    check("mux_ones_cycles", n_sel1, 10);
    check("mux_tens_blank_cycles", n_sel2, 10);
    check("mux_period", n_bad, 0);

    repeat (92) pulse(1'b1, 1);
    check("to_99", score(), 99);
    check("no_limit_at_99", int'(limit_o), 0);

    count_up_i = 1'b1;
    @(negedge clk_1khz);
    count_up_i = 1'b0;
    check("sat_hold_99", score(), 99);
    n = 0;
    while (limit_o && n < 2000) begin
      n++;
      @(negedge clk_1khz);
    end
    check("limit_len_up", n, 500);
    check("still_99", score(), 99);

    clear_i = 1'b1;
    @(negedge clk_1khz);
    clear_i = 1'b0;
    check("cleared", score(), 0);

    count_down_i = 1'b1;
    @(negedge clk_1khz);
    n = 0;
    while (limit_o && n < 2000) begin
      n++;
      if (n == 2) count_down_i = 1'b0;
      if (n == 100) count_down_i = 1'b1;
      if (n == 101) count_down_i = 1'b0;
      @(negedge clk_1khz);
    end
    check("limit_len_retrig", n, 600);
    check("sat_hold_00", score(), 0);
    check("limit_off", int'(limit_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
